// File: rtl/cs3_ctrl_fsm_v2.sv
// cs3_ctrl_fsm_v2 -- second-generation CS3 control unit.
// Decodes the IR opcode and drives the datapath strobes. Data memory accesses
// wait on mem_ready, and a watchdog aborts a stuck access to STOP with bus_err.
// Optional interrupt entry is compiled in with `define CS3_IRQ_EN.
module cs3_ctrl_fsm_v2 #(
   parameter int OPW   = 5,
   parameter int CONDW = 3,
   parameter int TOW   = 4
`ifdef CS3_IRQ_EN
   ,
   parameter logic [7:0] IRQ_VEC = 8'hF0
`endif
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [OPW-1:0]   op,
   input  logic [CONDW-1:0] condicion,
   input  logic [3:0]       regestado,
   input  logic             mem_ready,
`ifdef CS3_IRQ_EN
   input  logic             irq,
   output logic             irq_ack,
   output logic [7:0]       irq_vec,
`endif
   output logic             wmem,
   output logic             rmem,
   output logic             clpc,
   output logic             ipc,
   output logic             wir,
   output logic             wmar,
   output logic             inm,
   output logic             wreg,
   output logic             rac,
   output logic             wac,
   output logic             s,
   output logic             r,
   output logic             ta,
   output logic             tb,
   output logic             wpc,
   output logic             rpc,
   output logic             wsreg,
   output logic             isp,
   output logic             dsp,
   output logic             rsp,
   output logic             prsp,
   output logic             cin_sel,
   output logic             halted,
   output logic             ill_op,
   output logic             bus_err
);

   typedef enum logic [3:0] {
      S_STOP, S_FETCH, S_EXEC, S_WB, S_MAR, S_MEMRD, S_MEMWR, S_JMP,
      S_CMAR, S_CWR, S_RRD, S_I1, S_I2, S_I3, S_I4
   } state_t;

   localparam logic [4:0] OP_ST   = 5'b00000;
   localparam logic [4:0] OP_LD   = 5'b00001;
   localparam logic [4:0] OP_STS  = 5'b00010;
   localparam logic [4:0] OP_LDS  = 5'b00011;
   localparam logic [4:0] OP_CALL = 5'b00100;
   localparam logic [4:0] OP_RET  = 5'b00101;
   localparam logic [4:0] OP_BR   = 5'b00110;
   localparam logic [4:0] OP_JMP  = 5'b00111;
   localparam logic [4:0] OP_ADD  = 5'b01000;
   localparam logic [4:0] OP_SUB  = 5'b01010;
   localparam logic [4:0] OP_CP   = 5'b01011;
   localparam logic [4:0] OP_MOV  = 5'b01111;
   localparam logic [4:0] OP_STOP = 5'b10111;
   localparam logic [4:0] OP_SUBI = 5'b11010;
   localparam logic [4:0] OP_CPI  = 5'b11011;
   localparam logic [4:0] OP_SBCI = 5'b11100;
   localparam logic [4:0] OP_LDI  = 5'b11111;

   localparam logic [TOW-1:0] WDOG_MAX = '1;

   state_t         state_q, state_d;
   logic [TOW-1:0] wdog_q, wdog_d;
   logic           halted_q, halted_d;
   logic           ill_op_q, ill_op_d;
   logic           bus_err_q, bus_err_d;
`ifdef CS3_IRQ_EN
   logic           ie_q, ie_d;
`endif

   logic [4:0] op5;
   logic       op_hi_zero;
   logic [2:0] cond3;
   logic       cond_hi_zero;
   logic       br_cond;
   logic       br_taken;
   logic       in_mem_state;
   logic       waiting;
   logic       timeout;

   assign op5          = op[4:0];
   assign op_hi_zero   = ((op >> 5) == '0);
   assign cond3        = condicion[2:0];
   assign cond_hi_zero = ((condicion >> 3) == '0);

   // Branch condition evaluation from SREG {C,N,Z,V}; unused upper condition bits force not-taken
   always_comb begin
      br_cond = 1'b1;
      case (cond3)
         3'd0:    br_cond = regestado[1];
         3'd1:    br_cond = regestado[3];
         3'd2:    br_cond = regestado[0];
         3'd3:    br_cond = regestado[2] ^ regestado[0];
         3'd4:    br_cond = !regestado[1];
         3'd5:    br_cond = !regestado[3];
         3'd6:    br_cond = regestado[2];
         default: br_cond = 1'b1;
      endcase
      br_taken = br_cond && cond_hi_zero;
   end

   // Watchdog: counts cycles spent waiting on memory; mem_ready beats a timeout in the same cycle
   always_comb begin
      in_mem_state = (state_q == S_MEMRD) || (state_q == S_MEMWR) || (state_q == S_CWR) ||
                     (state_q == S_RRD) || (state_q == S_I3);
      waiting      = in_mem_state && !mem_ready;
      timeout      = waiting && (wdog_q == WDOG_MAX);
      wdog_d       = (waiting && !timeout) ? wdog_q + 1'b1 : '0;
   end

   // Next-state and strobe decode; strobes are forced low while reset is asserted
   always_comb begin
      state_d   = state_q;
      ill_op_d  = ill_op_q;
      bus_err_d = bus_err_q;
`ifdef CS3_IRQ_EN
      ie_d      = ie_q;
      irq_ack   = 1'b0;
      irq_vec   = 8'h00;
`endif
      wmem = 1'b0; rmem = 1'b0; clpc = 1'b0; ipc = 1'b0; wir = 1'b0; wmar = 1'b0;
      inm = 1'b0; wreg = 1'b0; rac = 1'b0; wac = 1'b0; s = 1'b0; r = 1'b0;
      ta = 1'b0; tb = 1'b0; wpc = 1'b0; rpc = 1'b0; wsreg = 1'b0; isp = 1'b0;
      dsp = 1'b0; rsp = 1'b0; prsp = 1'b0; cin_sel = 1'b0;
      if (!reset) begin
         case (state_q)
            S_STOP: begin
               if (start) begin
                  clpc = 1'b1; prsp = 1'b1;
                  ill_op_d = 1'b0; bus_err_d = 1'b0;
                  state_d = S_FETCH;
               end
            end
            S_FETCH: begin
`ifdef CS3_IRQ_EN
               if (irq && ie_q) begin
                  state_d = S_I1;
               end else begin
                  wir = 1'b1; ipc = 1'b1;
                  state_d = S_EXEC;
               end
`else
               wir = 1'b1; ipc = 1'b1;
               state_d = S_EXEC;
`endif
            end
            S_EXEC: begin
               if (!op_hi_zero) begin
                  ill_op_d = 1'b1; state_d = S_STOP;
               end else begin
                  case (op5)
                     OP_ADD:  begin s = 1'b1; wac = 1'b1; wsreg = 1'b1; state_d = S_WB; end
                     OP_SUB:  begin r = 1'b1; wac = 1'b1; wsreg = 1'b1; state_d = S_WB; end
                     OP_SUBI: begin r = 1'b1; inm = 1'b1; wac = 1'b1; wsreg = 1'b1; state_d = S_WB; end
                     OP_SBCI: begin r = 1'b1; inm = 1'b1; wac = 1'b1; wsreg = 1'b1; cin_sel = 1'b1; state_d = S_WB; end
                     OP_MOV:  begin ta = 1'b1; wac = 1'b1; state_d = S_WB; end
                     OP_LDI:  begin tb = 1'b1; inm = 1'b1; wac = 1'b1; state_d = S_WB; end
                     OP_CP:   begin r = 1'b1; wsreg = 1'b1; state_d = S_FETCH; end
                     OP_CPI:  begin r = 1'b1; inm = 1'b1; wsreg = 1'b1; state_d = S_FETCH; end
                     OP_LDS, OP_STS: begin tb = 1'b1; inm = 1'b1; wac = 1'b1; state_d = S_MAR; end
                     OP_LD, OP_ST:   begin tb = 1'b1; wac = 1'b1; state_d = S_MAR; end
                     OP_JMP:  begin tb = 1'b1; inm = 1'b1; wac = 1'b1; state_d = S_JMP; end
                     OP_CALL: begin tb = 1'b1; inm = 1'b1; wac = 1'b1; dsp = 1'b1; state_d = S_CMAR; end
                     OP_RET:  begin wmar = 1'b1; rsp = 1'b1; state_d = S_RRD; end
                     OP_BR: begin
                        if (br_taken) begin
                           tb = 1'b1; inm = 1'b1; wac = 1'b1; state_d = S_JMP;
                        end else begin
                           state_d = S_FETCH;
                        end
                     end
                     OP_STOP: state_d = S_STOP;
                     default: begin ill_op_d = 1'b1; state_d = S_STOP; end
                  endcase
               end
            end
            S_WB:   begin wreg = 1'b1; rac = 1'b1; state_d = S_FETCH; end
            S_MAR: begin
               wmar = 1'b1; rac = 1'b1;
               if ((op5 == OP_ST) || (op5 == OP_STS)) begin
                  ta = 1'b1; wac = 1'b1; state_d = S_MEMWR;
               end else begin
                  state_d = S_MEMRD;
               end
            end
            S_MEMRD: begin
               if (timeout) begin
                  bus_err_d = 1'b1; state_d = S_STOP;
               end else begin
                  rmem = 1'b1; wreg = 1'b1;
                  if (mem_ready) state_d = S_FETCH;
               end
            end
            S_MEMWR: begin
               if (timeout) begin
                  bus_err_d = 1'b1; state_d = S_STOP;
               end else begin
                  rac = 1'b1; wmem = 1'b1;
                  if (mem_ready) state_d = S_FETCH;
               end
            end
            S_JMP:  begin wpc = 1'b1; rac = 1'b1; state_d = S_FETCH; end
            S_CMAR: begin wmar = 1'b1; rsp = 1'b1; state_d = S_CWR; end
            S_CWR: begin
               if (timeout) begin
                  bus_err_d = 1'b1; state_d = S_STOP;
               end else begin
                  wmem = 1'b1; rpc = 1'b1;
                  if (mem_ready) state_d = S_JMP;
               end
            end
            S_RRD: begin
               if (timeout) begin
                  bus_err_d = 1'b1; state_d = S_STOP;
               end else begin
                  rmem = 1'b1; wpc = 1'b1;
                  if (mem_ready) begin
                     isp = 1'b1; state_d = S_FETCH;
`ifdef CS3_IRQ_EN
                     ie_d = 1'b1;
`endif
                  end
               end
            end
`ifdef CS3_IRQ_EN
            S_I1: begin dsp = 1'b1; irq_ack = 1'b1; state_d = S_I2; end
            S_I2: begin wmar = 1'b1; rsp = 1'b1; state_d = S_I3; end
            S_I3: begin
               if (timeout) begin
                  bus_err_d = 1'b1; state_d = S_STOP;
               end else begin
                  wmem = 1'b1; rpc = 1'b1;
                  if (mem_ready) state_d = S_I4;
               end
            end
            S_I4: begin
               wpc = 1'b1; inm = 1'b1; irq_vec = IRQ_VEC; ie_d = 1'b0; state_d = S_FETCH;
            end
`endif
            default: state_d = S_STOP;
         endcase
      end
      halted_d = (state_d == S_STOP);
   end

   // State, watchdog and registered status flags
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_STOP;
         wdog_q    <= '0;
         halted_q  <= 1'b1;
         ill_op_q  <= 1'b0;
         bus_err_q <= 1'b0;
`ifdef CS3_IRQ_EN
         ie_q      <= 1'b1;
`endif
      end else begin
         state_q   <= state_d;
         wdog_q    <= wdog_d;
         halted_q  <= halted_d;
         ill_op_q  <= ill_op_d;
         bus_err_q <= bus_err_d;
`ifdef CS3_IRQ_EN
         ie_q      <= ie_d;
`endif
      end
   end

   assign halted  = halted_q;
   assign ill_op  = ill_op_q;
   assign bus_err = bus_err_q;

endmodule

// File: tb/tb_cs3_ctrl_fsm_v2.sv
// tb_cs3_ctrl_fsm_v2 -- directed self-checking bench for cs3_ctrl_fsm_v2.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
// Interrupt scenarios compile in with `define CS3_IRQ_EN.
module tb_cs3_ctrl_fsm_v2;

   localparam logic [21:0] K_WMEM  = 22'd1 << 21;
   localparam logic [21:0] K_RMEM  = 22'd1 << 20;
   localparam logic [21:0] K_CLPC  = 22'd1 << 19;
   localparam logic [21:0] K_IPC   = 22'd1 << 18;
   localparam logic [21:0] K_WIR   = 22'd1 << 17;
   localparam logic [21:0] K_WMAR  = 22'd1 << 16;
   localparam logic [21:0] K_INM   = 22'd1 << 15;
   localparam logic [21:0] K_WREG  = 22'd1 << 14;
   localparam logic [21:0] K_RAC   = 22'd1 << 13;
   localparam logic [21:0] K_WAC   = 22'd1 << 12;
   localparam logic [21:0] K_S     = 22'd1 << 11;
   localparam logic [21:0] K_R     = 22'd1 << 10;
   localparam logic [21:0] K_TA    = 22'd1 << 9;
   localparam logic [21:0] K_TB    = 22'd1 << 8;
   localparam logic [21:0] K_WPC   = 22'd1 << 7;
   localparam logic [21:0] K_RPC   = 22'd1 << 6;
   localparam logic [21:0] K_WSREG = 22'd1 << 5;
   localparam logic [21:0] K_ISP   = 22'd1 << 4;
   localparam logic [21:0] K_DSP   = 22'd1 << 3;
   localparam logic [21:0] K_RSP   = 22'd1 << 2;
   localparam logic [21:0] K_PRSP  = 22'd1 << 1;
   localparam logic [21:0] K_CIN   = 22'd1;
   localparam logic [21:0] K_FETCH = K_WIR | K_IPC;

   localparam logic [4:0] OP_ST   = 5'b00000;
   localparam logic [4:0] OP_LD   = 5'b00001;
   localparam logic [4:0] OP_LDS  = 5'b00011;
   localparam logic [4:0] OP_CALL = 5'b00100;
   localparam logic [4:0] OP_RET  = 5'b00101;
   localparam logic [4:0] OP_BR   = 5'b00110;
   localparam logic [4:0] OP_JMP  = 5'b00111;
   localparam logic [4:0] OP_ADD  = 5'b01000;
   localparam logic [4:0] OP_SUB  = 5'b01010;
   localparam logic [4:0] OP_CP   = 5'b01011;
   localparam logic [4:0] OP_MOV  = 5'b01111;
   localparam logic [4:0] OP_STOP = 5'b10111;
   localparam logic [4:0] OP_SUBI = 5'b11010;
   localparam logic [4:0] OP_CPI  = 5'b11011;
   localparam logic [4:0] OP_SBCI = 5'b11100;
   localparam logic [4:0] OP_LDI  = 5'b11111;
   localparam logic [4:0] OP_ILL  = 5'b10000;

   typedef struct packed {
      logic [4:0]  op;
      logic        mr;
      logic [21:0] e;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset, start, mem_ready;
   logic [4:0] op;
   logic [2:0] condicion;
   logic [3:0] regestado;
   logic wmem, rmem, clpc, ipc, wir, wmar, inm, wreg, rac, wac, s, r, ta, tb;
   logic wpc, rpc, wsreg, isp, dsp, rsp, prsp, cin_sel;
   logic halted, ill_op, bus_err;
`ifdef CS3_IRQ_EN
   logic       irq, irq_ack;
   logic [7:0] irq_vec;
`endif
   logic [21:0] strb;

   int   checks   = 0;
   int   failures = 0;
   vec_t vq[$];

   assign strb = {wmem, rmem, clpc, ipc, wir, wmar, inm, wreg, rac, wac, s, r, ta, tb,
                  wpc, rpc, wsreg, isp, dsp, rsp, prsp, cin_sel};

   always #5 clk = ~clk;

   cs3_ctrl_fsm_v2 dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .condicion(condicion),
      .regestado(regestado), .mem_ready(mem_ready),
`ifdef CS3_IRQ_EN
      .irq(irq), .irq_ack(irq_ack), .irq_vec(irq_vec),
`endif
      .wmem(wmem), .rmem(rmem), .clpc(clpc), .ipc(ipc), .wir(wir), .wmar(wmar),
      .inm(inm), .wreg(wreg), .rac(rac), .wac(wac), .s(s), .r(r), .ta(ta), .tb(tb),
      .wpc(wpc), .rpc(rpc), .wsreg(wsreg), .isp(isp), .dsp(dsp), .rsp(rsp),
      .prsp(prsp), .cin_sel(cin_sel), .halted(halted), .ill_op(ill_op), .bus_err(bus_err)
   );

   function automatic vec_t mk(input logic [4:0] o, input logic m, input logic [21:0] e);
      vec_t v;
      v.op = o; v.mr = m; v.e = e;
      return v;
   endfunction

   // Reset values, start pulse, first fetch; leaves the FSM at a fresh FETCH
   task automatic test_reset();
      reset = 1'b1; start = 1'b1; op = OP_CP;
      @(negedge clk); #1;
      checks += 4;
      if (strb !== 22'd0) begin failures++; $display("[TB] FAIL reset_strobes got %06h want 000000", strb); end
      if (halted !== 1'b1) begin failures++; $display("[TB] FAIL reset_halted got %b want 1", halted); end
      if (ill_op !== 1'b0) begin failures++; $display("[TB] FAIL reset_ill_op got %b want 0", ill_op); end
      if (bus_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_bus_err got %b want 0", bus_err); end
      @(negedge clk); reset = 1'b0; #1;
      checks += 2;
      if (strb !== (K_CLPC | K_PRSP)) begin failures++; $display("[TB] FAIL start_strobes got %06h want %06h", strb, K_CLPC | K_PRSP); end
      if (halted !== 1'b1) begin failures++; $display("[TB] FAIL start_halted got %b want 1", halted); end
      @(negedge clk); start = 1'b0; #1;
      checks += 2;
      if (halted !== 1'b0) begin failures++; $display("[TB] FAIL run_halted got %b want 0", halted); end
      if (strb !== K_FETCH) begin failures++; $display("[TB] FAIL first_fetch got %06h want %06h", strb, K_FETCH); end
      @(negedge clk); #1;
      checks++;
      if (strb !== (K_R | K_WSREG)) begin failures++; $display("[TB] FAIL cp_exec got %06h want %06h", strb, K_R | K_WSREG); end
      @(negedge clk);
   endtask

   // ALU / immediate / compare / jump instructions: fetch, exec, optional second cycle
   task automatic test_alu();
      logic [4:0]  ops [9] = '{OP_ADD, OP_SUB, OP_SUBI, OP_SBCI, OP_MOV, OP_LDI, OP_CP, OP_CPI, OP_JMP};
      logic [21:0] ex  [9] = '{K_S|K_WAC|K_WSREG, K_R|K_WAC|K_WSREG, K_R|K_INM|K_WAC|K_WSREG,
                               K_R|K_INM|K_WAC|K_WSREG|K_CIN, K_TA|K_WAC, K_TB|K_INM|K_WAC,
                               K_R|K_WSREG, K_R|K_INM|K_WSREG, K_TB|K_INM|K_WAC};
      logic [21:0] sc  [9] = '{K_WREG|K_RAC, K_WREG|K_RAC, K_WREG|K_RAC, K_WREG|K_RAC,
                               K_WREG|K_RAC, K_WREG|K_RAC, 22'd0, 22'd0, K_WPC|K_RAC};
      regestado = 4'b1111;
      for (int i = 0; i < 9; i++) begin
         op = ops[i]; #1;
         checks++;
         if (strb !== K_FETCH) begin failures++; $display("[TB] FAIL alu_fetch[%0d] got %06h want %06h", i, strb, K_FETCH); end
         @(negedge clk); #1;
         checks++;
         if (strb !== ex[i]) begin failures++; $display("[TB] FAIL alu_exec[%0d] got %06h want %06h", i, strb, ex[i]); end
         @(negedge clk);
         if (sc[i] != 22'd0) begin
            #1;
            checks++;
            if (strb !== sc[i]) begin failures++; $display("[TB] FAIL alu_second[%0d] got %06h want %06h", i, strb, sc[i]); end
            @(negedge clk);
         end
      end
   endtask

   // Branch conditions against SREG {C,N,Z,V}
   task automatic test_branch();
      logic [2:0] cnd [10] = '{3'd4, 3'd4, 3'd7, 3'd0, 3'd1, 3'd3, 3'd3, 3'd5, 3'd6, 3'd2};
      logic [3:0] sr  [10] = '{4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0100, 4'b0101, 4'b0000, 4'b0000, 4'b0001};
      logic       tk  [10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      op = OP_BR;
      for (int i = 0; i < 10; i++) begin
         condicion = cnd[i]; regestado = sr[i]; #1;
         checks++;
         if (strb !== K_FETCH) begin failures++; $display("[TB] FAIL br_fetch[%0d] got %06h want %06h", i, strb, K_FETCH); end
         @(negedge clk); #1;
         checks++;
         if (strb !== (tk[i] ? (K_TB|K_INM|K_WAC) : 22'd0)) begin
            failures++; $display("[TB] FAIL br_exec[%0d] got %06h taken_expected=%b", i, strb, tk[i]);
         end
         @(negedge clk);
         if (tk[i]) begin
            #1;
            checks++;
            if (strb !== (K_WPC|K_RAC)) begin failures++; $display("[TB] FAIL br_jmp[%0d] got %06h want %06h", i, strb, K_WPC|K_RAC); end
            @(negedge clk);
         end
      end
   endtask

   // LD with three wait cycles, then zero-wait LDS
   task automatic test_mem_wait();
      vq.delete();
      vq.push_back(mk(OP_LD, 1'b1, K_FETCH));
      vq.push_back(mk(OP_LD, 1'b1, K_TB|K_WAC));
      vq.push_back(mk(OP_LD, 1'b1, K_WMAR|K_RAC));
      repeat (3) vq.push_back(mk(OP_LD, 1'b0, K_RMEM|K_WREG));
      vq.push_back(mk(OP_LD, 1'b1, K_RMEM|K_WREG));
      vq.push_back(mk(OP_LDS, 1'b1, K_FETCH));
      vq.push_back(mk(OP_LDS, 1'b1, K_TB|K_INM|K_WAC));
      vq.push_back(mk(OP_LDS, 1'b1, K_WMAR|K_RAC));
      vq.push_back(mk(OP_LDS, 1'b1, K_RMEM|K_WREG));
      foreach (vq[i]) begin
         op = vq[i].op; mem_ready = vq[i].mr; #1;
         checks++;
         if (strb !== vq[i].e) begin failures++; $display("[TB] FAIL ld_wait[%0d] got %06h want %06h", i, strb, vq[i].e); end
         @(negedge clk);
      end
   endtask

   // CALL with one wait cycle on the push, RET with one wait cycle on the pop
   task automatic test_call_ret();
      vq.delete();
      vq.push_back(mk(OP_CALL, 1'b1, K_FETCH));
      vq.push_back(mk(OP_CALL, 1'b1, K_TB|K_INM|K_WAC|K_DSP));
      vq.push_back(mk(OP_CALL, 1'b1, K_WMAR|K_RSP));
      vq.push_back(mk(OP_CALL, 1'b0, K_WMEM|K_RPC));
      vq.push_back(mk(OP_CALL, 1'b1, K_WMEM|K_RPC));
      vq.push_back(mk(OP_CALL, 1'b1, K_WPC|K_RAC));
      vq.push_back(mk(OP_RET, 1'b1, K_FETCH));
      vq.push_back(mk(OP_RET, 1'b1, K_WMAR|K_RSP));
      vq.push_back(mk(OP_RET, 1'b0, K_RMEM|K_WPC));
      vq.push_back(mk(OP_RET, 1'b1, K_RMEM|K_WPC|K_ISP));
      vq.push_back(mk(OP_CP, 1'b1, K_FETCH));
      vq.push_back(mk(OP_CP, 1'b1, K_R|K_WSREG));
      foreach (vq[i]) begin
         op = vq[i].op; mem_ready = vq[i].mr; #1;
         checks++;
         if (strb !== vq[i].e) begin failures++; $display("[TB] FAIL call_ret[%0d] got %06h want %06h", i, strb, vq[i].e); end
         @(negedge clk);
      end
   endtask

   // ST that never completes times out; restart, then ST that completes on the last allowed cycle
   task automatic test_timeout();
      vq.delete();
      vq.push_back(mk(OP_ST, 1'b0, K_FETCH));
      vq.push_back(mk(OP_ST, 1'b0, K_TB|K_WAC));
      vq.push_back(mk(OP_ST, 1'b0, K_WMAR|K_RAC|K_TA|K_WAC));
      repeat (15) vq.push_back(mk(OP_ST, 1'b0, K_WMEM|K_RAC));
      vq.push_back(mk(OP_ST, 1'b0, 22'd0));
      foreach (vq[i]) begin
         op = vq[i].op; mem_ready = vq[i].mr; #1;
         checks++;
         if (strb !== vq[i].e) begin failures++; $display("[TB] FAIL st_timeout[%0d] got %06h want %06h", i, strb, vq[i].e); end
         @(negedge clk);
      end
      #1;
      checks += 3;
      if (halted !== 1'b1) begin failures++; $display("[TB] FAIL timeout_halted got %b want 1", halted); end
      if (bus_err !== 1'b1) begin failures++; $display("[TB] FAIL timeout_bus_err got %b want 1", bus_err); end
      if (strb !== 22'd0) begin failures++; $display("[TB] FAIL timeout_stop_strobes got %06h want 000000", strb); end
      start = 1'b1; #1;
      @(negedge clk); start = 1'b0;
      vq.delete();
      vq.push_back(mk(OP_ST, 1'b0, K_FETCH));
      vq.push_back(mk(OP_ST, 1'b0, K_TB|K_WAC));
      vq.push_back(mk(OP_ST, 1'b0, K_WMAR|K_RAC|K_TA|K_WAC));
      repeat (15) vq.push_back(mk(OP_ST, 1'b0, K_WMEM|K_RAC));
      vq.push_back(mk(OP_ST, 1'b1, K_WMEM|K_RAC));
      foreach (vq[i]) begin
         op = vq[i].op; mem_ready = vq[i].mr; #1;
         checks++;
         if (strb !== vq[i].e) begin failures++; $display("[TB] FAIL st_limit[%0d] got %06h want %06h", i, strb, vq[i].e); end
         @(negedge clk);
      end
      op = OP_CP; #1;
      checks += 3;
      if (strb !== K_FETCH) begin failures++; $display("[TB] FAIL limit_fetch got %06h want %06h", strb, K_FETCH); end
      if (bus_err !== 1'b0) begin failures++; $display("[TB] FAIL limit_bus_err got %b want 0", bus_err); end
      if (halted !== 1'b0) begin failures++; $display("[TB] FAIL limit_halted got %b want 0", halted); end
      @(negedge clk); @(negedge clk);
   endtask

   // Illegal opcode trap, STOP opcode, and start held across STOP re-entry
   task automatic test_illegal();
      op = OP_ILL; #1;
      @(negedge clk); #1;
      checks++;
      if (strb !== 22'd0) begin failures++; $display("[TB] FAIL ill_exec got %06h want 000000", strb); end
      @(negedge clk); #1;
      checks += 2;
      if (halted !== 1'b1) begin failures++; $display("[TB] FAIL ill_halted got %b want 1", halted); end
      if (ill_op !== 1'b1) begin failures++; $display("[TB] FAIL ill_flag got %b want 1", ill_op); end
      start = 1'b1; op = OP_STOP; #1;
      checks++;
      if (strb !== (K_CLPC|K_PRSP)) begin failures++; $display("[TB] FAIL ill_restart got %06h want %06h", strb, K_CLPC|K_PRSP); end
      @(negedge clk); #1;
      checks++;
      if (ill_op !== 1'b0) begin failures++; $display("[TB] FAIL ill_cleared got %b want 0", ill_op); end
      @(negedge clk); #1;
      @(negedge clk); #1;
      checks += 3;
      if (halted !== 1'b1) begin failures++; $display("[TB] FAIL stop_op_halted got %b want 1", halted); end
      if (ill_op !== 1'b0) begin failures++; $display("[TB] FAIL stop_op_ill got %b want 0", ill_op); end
      if (strb !== (K_CLPC|K_PRSP)) begin failures++; $display("[TB] FAIL held_start got %06h want %06h", strb, K_CLPC|K_PRSP); end
      @(negedge clk); start = 1'b0; op = OP_CP;
   endtask

   // Asynchronous reset in the middle of a waiting load
   task automatic test_reset_midop();
      op = OP_LD; mem_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (strb !== (K_RMEM|K_WREG)) begin failures++; $display("[TB] FAIL midop_wait got %06h want %06h", strb, K_RMEM|K_WREG); end
      #2 reset = 1'b1; #1;
      checks += 2;
      if (strb !== 22'd0) begin failures++; $display("[TB] FAIL midop_strobes got %06h want 000000", strb); end
      if (halted !== 1'b1) begin failures++; $display("[TB] FAIL midop_halted got %b want 1", halted); end
      @(negedge clk); reset = 1'b0; start = 1'b1; op = OP_CP; #1;
      checks++;
      if (strb !== (K_CLPC|K_PRSP)) begin failures++; $display("[TB] FAIL midop_restart got %06h want %06h", strb, K_CLPC|K_PRSP); end
      @(negedge clk); start = 1'b0;
   endtask

`ifdef CS3_IRQ_EN
   // Interrupt entry, ie masking until RET, and re-entry once ie is restored
   task automatic test_irq();
      logic [4:0]  o  [15] = '{OP_CP, OP_CP, OP_CP, OP_CP, OP_CP, OP_CP, OP_CP, OP_RET, OP_RET, OP_RET,
                               OP_CP, OP_CP, OP_CP, OP_CP, OP_CP};
      logic        iq [15] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                               1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      logic [21:0] e  [15] = '{22'd0, K_DSP, K_WMAR|K_RSP, K_WMEM|K_RPC, K_WPC|K_INM, K_FETCH,
                               K_R|K_WSREG, K_FETCH, K_WMAR|K_RSP, K_RMEM|K_WPC|K_ISP,
                               22'd0, K_DSP, K_WMAR|K_RSP, K_WMEM|K_RPC, K_WPC|K_INM};
      logic        ak [15] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                               1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      mem_ready = 1'b1;
      for (int i = 0; i < 15; i++) begin
         op = o[i]; irq = iq[i]; #1;
         checks += 2;
         if (strb !== e[i]) begin failures++; $display("[TB] FAIL irq_strobes[%0d] got %06h want %06h", i, strb, e[i]); end
         if (irq_ack !== ak[i]) begin failures++; $display("[TB] FAIL irq_ack[%0d] got %b want %b", i, irq_ack, ak[i]); end
         if (e[i] == (K_WPC|K_INM)) begin
            checks++;
            if (irq_vec !== 8'hF0) begin failures++; $display("[TB] FAIL irq_vec[%0d] got %02h want f0", i, irq_vec); end
         end
         @(negedge clk);
      end
      irq = 1'b0;
   endtask
`endif

   // Test sequence
   initial begin
      reset = 1'b1; start = 1'b0; op = OP_CP; condicion = 3'd0; regestado = 4'd0; mem_ready = 1'b1;
`ifdef CS3_IRQ_EN
      irq = 1'b0;
`endif
      test_reset();
      test_alu();
      test_branch();
      test_mem_wait();
      test_call_ret();
      test_timeout();
      test_illegal();
      test_reset_midop();
`ifdef CS3_IRQ_EN
      test_irq();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
